seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; only 32 is supported.
REQ-002 clock  input  1  the single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ctrl_div  input  1  start pulse; operands are sampled on the edge where it is high.
REQ-005 dividend  input  32  signed two's-complement dividend.
REQ-006 divisor  input  32  signed two's-complement divisor.
REQ-007 quotient  output  32  signed quotient, registered.
REQ-008 remainder  output  32  signed remainder, registered.
REQ-009 data_exception  output  1  divide-by-zero or overflow, registered, valid with result_ready.
REQ-010 result_ready  output  1  one-cycle pulse: result valid.
REQ-011 busy  output  1  high while an operation is in flight.

Function
REQ-012 FSM states: IDLE, ITER, FIX, DONE.
REQ-013 IDLE: ctrl_div high -> capture |dividend|, |divisor| and both sign bits, clear the 64-bit remainder/quotient register and the 6-bit counter, go to ITER.
REQ-014 ITER: one restoring step per cycle:
- shift the {rem, quo} register left by 1;
- trial subtract |divisor| from the upper 33 bits;
- if the trial is non-negative, keep the difference and set quo[0]=1;
- else restore and set quo[0]=0.
REQ-015 Leave ITER after exactly 32 steps (counter 0..31), then go to FIX.
REQ-016 FIX sign rules:
- negate the quotient if sign(dividend) xor sign(divisor);
- negate the remainder if sign(dividend);
- then write quotient, remainder and data_exception, and go to DONE.
REQ-017 DONE: result_ready=1 for exactly one cycle, then return to IDLE.
REQ-018 Latency: start at edge N gives result_ready high in cycle N+34; the 34 cycles are 1 capture, 32 ITER and 1 FIX.
REQ-019 Quotient truncates toward zero; the remainder carries the dividend sign; |remainder| < |divisor|.
REQ-020 Divisor == 0: quotient=0, remainder=dividend, data_exception=1.
REQ-021 dividend == 0x80000000 with divisor == 0xFFFFFFFF: quotient=0x80000000, remainder=0, data_exception=1.
REQ-022 All other operands: data_exception=0.
REQ-023 ctrl_div while busy aborts the current operation, captures the new operands that cycle, and restarts at ITER step 0; no result_ready is issued for the aborted operation.
REQ-024 ctrl_div in the DONE cycle: result_ready still pulses, and the new operation starts as in REQ-013.
REQ-025 busy is high in ITER and FIX, low in IDLE and DONE.
REQ-026 quotient, remainder and data_exception hold their values until the next FIX write.
REQ-027 |0x80000000| is handled as the unsigned value 2^31; the 33-bit datapath is used, with no overflow.

Reset
REQ-028 reset high at any clock edge forces IDLE and clears the counter and the internal register.
REQ-029 reset also forces quotient=0, remainder=0, data_exception=0, result_ready=0, busy=0.
REQ-030 reset overrides a simultaneous ctrl_div; an operation in progress is discarded with no pulse.

Configuration
REQ-031 Macro DIV_EARLY_ZERO_EN defined: if divisor==0 or dividend==0 at capture, skip ITER and FIX.
REQ-032 With DIV_EARLY_ZERO_EN, that early result is written at capture and result_ready pulses in cycle N+1, with values as in REQ-020 (quotient=0, remainder=0 for a zero dividend).
REQ-033 Macro DIV_EARLY_ZERO_EN undefined: every operation takes the 34-cycle latency of REQ-018.

Structure
REQ-034 Shared package holds:
- the FSM state enum;
- DIV_WIDTH=32;
- DIV_STEPS=32;
- constant INT_MIN=0x80000000.
REQ-035 Sub-module div_step: the combinational shift/trial-subtract/restore of one iteration, instantiated once; the FSM, counter and sign fix-up stay in seq_divider.

Verification
REQ-036 The bench shall cover these directed scenarios:
- 100 / 7 -> quotient 14, remainder 2, exception 0, result_ready exactly 34 cycles after start;
- -100 / 7 -> quotient -14 (0xFFFFFFF2), remainder -2; and 100 / -7 -> quotient -14, remainder 2;
- 5 / 0 -> quotient 0, remainder 5, exception 1; latency 1 with DIV_EARLY_ZERO_EN, 34 without;
- 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, exception 1; and 0x80000000 / 2 -> 0xC0000000, exception 0;
- start 1000/3, re-start 9/4 at cycle 10 -> a single result_ready, 34 cycles after the second start, quotient 2, remainder 1;
- reset asserted at cycle 20 of an operation -> all outputs 0, busy 0, no result_ready pulse, next operation correct.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM states, widths, INT_MIN.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division iteration on the {rem, quo} register.
// Zero latency; no flow control.
module div_step
    import seq_divider_pkg::*;
(
    input  logic [2*DIV_WIDTH-1:0] i_acc,
    input  logic [DIV_WIDTH-1:0]   i_dsr,
    output logic [2*DIV_WIDTH-1:0] o_acc
);

    logic [DIV_WIDTH:0] w_hi;
    logic [DIV_WIDTH:0] w_trial;

    // Upper 33 bits of {rem, quo} after the left shift.
    assign w_hi    = i_acc[2*DIV_WIDTH-1:DIV_WIDTH-1];
    assign w_trial = w_hi - {1'b0, i_dsr};

    assign o_acc = {(w_trial[DIV_WIDTH] ? w_hi[DIV_WIDTH-1:0] : w_trial[DIV_WIDTH-1:0]),
                    i_acc[DIV_WIDTH-2:0],
                    ~w_trial[DIV_WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// seq_divider: 32-bit signed restoring divider, 34 cycles from start to result_ready; no backpressure, a new start aborts.
// Optional macro DIV_EARLY_ZERO_EN: zero divisor or dividend completes at capture (result_ready next cycle).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             data_exception,
    output logic             result_ready,
    output logic             busy
);

    div_state_t             r_state;
    div_state_t             w_next;
    logic [5:0]             r_cnt;
    logic [2*DIV_WIDTH-1:0] r_acc;
    logic [2*DIV_WIDTH-1:0] w_step_acc;
    logic [DIV_WIDTH-1:0]   r_dsr_abs;
    logic                   r_sgn_dvd;
    logic                   r_sgn_dsr;
    logic                   r_dsr_zero;
    logic                   r_ovf;
    logic [DIV_WIDTH-1:0]   w_dvd_abs;
    logic [DIV_WIDTH-1:0]   w_dsr_abs;
    logic [DIV_WIDTH-1:0]   w_quo;
    logic [DIV_WIDTH-1:0]   w_rem;
    logic                   w_early;

    // INT_MIN negates to itself, which read unsigned is exactly 2^31.
    assign w_dvd_abs = dividend[DIV_WIDTH-1] ? -dividend : dividend;
    assign w_dsr_abs = divisor[DIV_WIDTH-1]  ? -divisor  : divisor;

`ifdef DIV_EARLY_ZERO_EN
    assign w_early = (divisor == '0) || (dividend == '0);
`else
    assign w_early = 1'b0;
`endif

    div_step u_step (
        .i_acc (r_acc),
        .i_dsr (r_dsr_abs),
        .o_acc (w_step_acc)
    );

    assign w_quo = r_acc[DIV_WIDTH-1:0];
    assign w_rem = r_acc[2*DIV_WIDTH-1:DIV_WIDTH];

    always_comb begin
        w_next = r_state;
        if (ctrl_div) begin
            w_next = w_early ? DONE : ITER;
        end else begin
            case (r_state)
                IDLE: w_next = IDLE;
                ITER: if (r_cnt == 6'(DIV_STEPS - 1)) w_next = FIX;
                FIX:  w_next = DONE;
                DONE: w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt          <= '0;
            r_acc          <= '0;
            r_dsr_abs      <= '0;
            r_sgn_dvd      <= 1'b0;
            r_sgn_dsr      <= 1'b0;
            r_dsr_zero     <= 1'b0;
            r_ovf          <= 1'b0;
            quotient       <= '0;
            remainder      <= '0;
            data_exception <= 1'b0;
        end else if (ctrl_div) begin
            r_cnt      <= '0;
            r_acc      <= {{DIV_WIDTH{1'b0}}, w_dvd_abs};
            r_dsr_abs  <= w_dsr_abs;
            r_sgn_dvd  <= dividend[DIV_WIDTH-1];
            r_sgn_dsr  <= divisor[DIV_WIDTH-1];
            r_dsr_zero <= (divisor == '0);
            r_ovf      <= (dividend == INT_MIN) && (divisor == '1);
            if (w_early) begin
                quotient       <= '0;
                remainder      <= dividend;
                data_exception <= (divisor == '0);
            end
        end else if (r_state == ITER) begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt + 6'd1;
        end else if (r_state == FIX) begin
            // With a zero divisor every trial succeeds, so rem ends as |dividend|.
            quotient       <= r_dsr_zero ? '0 : ((r_sgn_dvd ^ r_sgn_dsr) ? -w_quo : w_quo);
            remainder      <= r_sgn_dvd ? -w_rem : w_rem;
            data_exception <= r_dsr_zero | r_ovf;
        end
    end

    assign result_ready = (r_state == DONE);
    assign busy         = (r_state == ITER) || (r_state == FIX);

endmodule
